drop_scheduler: RTL and testbench

- Game-flow controller that sequences the active piece's descent: gravity timing per level, soft/hard drop, lock delay, line-clear bookkeeping and level advance.
- Sits between the player-input debouncers and the board datapath.
- Issues step-down and lock requests to the board over req/ack handshakes, and owns the level register that drives gravity speed and the display.

---
 rtl/drop_scheduler_pkg.sv | 36 +++
 rtl/drop_scheduler_gravity_lut.sv | 21 ++
 rtl/drop_scheduler.sv | 156 +++++++++++++++
 tb/tb_drop_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/drop_scheduler_pkg.sv
// Shared types and constants for the piece-descent scheduler: level width,
// gravity speed table and FSM state encodings.
package drop_scheduler_pkg;
  localparam int LEVEL_LEN     = 4;
  localparam int DEF_MAX_LEVEL = 14;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_WAIT,
    DS_REQ,
    DS_LOCK,
    DS_COMMIT
  } ds_state_e;

  // Unscaled gravity period in cycles; levels past the table stay at the fastest entry.
  function automatic logic [33:0] speed_of(input logic [LEVEL_LEN-1:0] lvl);
    logic [33:0] s;
    case (int'(lvl))
      0:       s = 34'd100_000_000;
      1:       s = 34'd80_000_000;
      2:       s = 34'd60_000_000;
      3:       s = 34'd40_000_000;
      4:       s = 34'd20_000_000;
      5:       s = 34'd9_000_000;
      6:       s = 34'd8_000_000;
      7:       s = 34'd7_000_000;
      8:       s = 34'd6_000_000;
      9:       s = 34'd5_000_000;
      10:      s = 34'd4_000_000;
      11:      s = 34'd3_000_000;
      12:      s = 34'd2_000_000;
      default: s = 34'd1_000_000;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/drop_scheduler_gravity_lut.sv
// Gravity period lookup: (level, soft_drop) -> cycles between step requests.
// Pure combinational so the preview/display path can share it.
module drop_scheduler_gravity_lut
  import drop_scheduler_pkg::*;
#(
  parameter int PERIOD_SCALE = 1,
  parameter int SOFT_PERIOD  = 1_000_000
) (
  input  logic [LEVEL_LEN-1:0] level_i,
  input  logic                 soft_drop_i,
  output logic [33:0]          period_o
);
  logic [33:0] grav;

  always_comb begin
    grav     = speed_of(level_i) / 34'(PERIOD_SCALE);
    period_o = (soft_drop_i && (grav > 34'(SOFT_PERIOD))) ? 34'(SOFT_PERIOD) : grav;
    // A zero period would underflow the compare; treat it as every cycle.
    if (period_o == '0) period_o = 34'd1;
  end
endmodule

// File: rtl/drop_scheduler.sv
// Game-flow controller: gravity timing, soft/hard drop, lock delay,
// line-clear bookkeeping and level advance, talking to the board over req/ack.
module drop_scheduler
  import drop_scheduler_pkg::*;
#(
  parameter int PERIOD_SCALE    = 1,
  parameter int SOFT_PERIOD     = 1_000_000,
  parameter int LOCK_CYCLES     = 50_000_000,
  parameter int LINES_PER_LEVEL = 10,
  parameter int START_LEVEL     = 0,
  parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 game_over_i,
  input  logic                 soft_drop_i,
  input  logic                 hard_drop_i,
  input  logic                 piece_moved_i,
  output logic                 step_req_o,
  input  logic                 step_ack_i,
  input  logic                 step_ok_i,
  output logic                 lock_req_o,
  input  logic                 lock_ack_i,
  input  logic [2:0]           lines_cleared_i,
  output logic [LEVEL_LEN-1:0] level_o,
  output logic [15:0]          lines_total_o,
  output logic                 running_o
);
  ds_state_e            state_q, state_d;
  logic [33:0]          cnt_q, cnt_d, period;
  logic                 hd_q, hd_d;
  logic [15:0]          lil_q, lil_d, lil_sum;
  logic [LEVEL_LEN-1:0] level_q, level_d;
  logic [15:0]          lines_q, lines_d;
  logic [16:0]          lines_sum;
  logic                 running_q, running_d;
  logic                 step_req_q, lock_req_q;
  logic [2:0]           n_lines;

  drop_scheduler_gravity_lut #(
    .PERIOD_SCALE(PERIOD_SCALE),
    .SOFT_PERIOD (SOFT_PERIOD)
  ) u_lut (
    .level_i    (level_q),
    .soft_drop_i(soft_drop_i),
    .period_o   (period)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hd_d      = hd_q;
    lil_d     = lil_q;
    level_d   = level_q;
    lines_d   = lines_q;
    running_d = running_q;
    n_lines   = (lines_cleared_i > 3'd4) ? 3'd4 : lines_cleared_i;
    lines_sum = {1'b0, lines_q} + 17'(n_lines);
    lil_sum   = lil_q + 16'(n_lines);

    case (state_q)
      DS_IDLE: if (start_i) begin
        level_d   = LEVEL_LEN'(START_LEVEL);
        lines_d   = '0;
        lil_d     = '0;
        running_d = 1'b1;
        cnt_d     = '0;
        hd_d      = 1'b0;
        state_d   = DS_WAIT;
      end
      DS_WAIT: begin
        cnt_d = cnt_q + 34'd1;
        if (hd_q || hard_drop_i) begin
          hd_d    = 1'b1;
          cnt_d   = '0;
          state_d = DS_REQ;
        end else if (cnt_q >= period - 34'd1) begin
          cnt_d   = '0;
          state_d = DS_REQ;
        end
      end
      DS_REQ: begin
        if (hard_drop_i) hd_d = 1'b1;
        if (step_ack_i) begin
          cnt_d = '0;
          if (step_ok_i)                 state_d = DS_WAIT;
          else if (hd_q || hard_drop_i)  state_d = DS_COMMIT;
          else                           state_d = DS_LOCK;
        end
      end
      DS_LOCK: begin
        cnt_d = cnt_q + 34'd1;
        // A successful move always retries gravity, even on the expiry cycle.
        if (piece_moved_i) begin
          cnt_d   = '0;
          state_d = DS_WAIT;
        end else if (hard_drop_i || (cnt_q >= 34'(LOCK_CYCLES - 1))) begin
          cnt_d   = '0;
          state_d = DS_COMMIT;
        end
      end
      DS_COMMIT: if (lock_ack_i) begin
        lines_d = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
        if (lil_sum >= 16'(LINES_PER_LEVEL)) begin
          lil_d = lil_sum - 16'(LINES_PER_LEVEL);
          if (level_q < LEVEL_LEN'(MAX_LEVEL)) level_d = level_q + 1'b1;
        end else begin
          lil_d = lil_sum;
        end
        hd_d    = 1'b0;
        cnt_d   = '0;
        state_d = DS_WAIT;
      end
      default: state_d = DS_IDLE;
    endcase

    // Level and line count are kept for the display after the game ends.
    if (game_over_i) begin
      state_d   = DS_IDLE;
      running_d = 1'b0;
      cnt_d     = '0;
      hd_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DS_IDLE;
      cnt_q      <= '0;
      hd_q       <= 1'b0;
      lil_q      <= '0;
      level_q    <= '0;
      lines_q    <= '0;
      running_q  <= 1'b0;
      step_req_q <= 1'b0;
      lock_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hd_q       <= hd_d;
      lil_q      <= lil_d;
      level_q    <= level_d;
      lines_q    <= lines_d;
      running_q  <= running_d;
      step_req_q <= (state_d == DS_REQ);
      lock_req_q <= (state_d == DS_COMMIT);
    end
  end

  assign step_req_o    = step_req_q;
  assign lock_req_o    = lock_req_q;
  assign level_o       = level_q;
  assign lines_total_o = lines_q;
  assign running_o     = running_q;
endmodule

// File: tb/tb_drop_scheduler.sv
// Directed bench for drop_scheduler: two instances (start level 0 and 13)
// share one stimulus set, steered by sel.
module tb_drop_scheduler;
  import drop_scheduler_pkg::*;

  logic clk, rst_n, sel;
  logic start, game_over, soft_drop, hard_drop, piece_moved;
  logic step_ack, step_ok, lock_ack;
  logic [2:0] lines_cleared;

  logic a_step_req, a_lock_req, a_running, b_step_req, b_lock_req, b_running;
  logic [LEVEL_LEN-1:0] a_level, b_level;
  logic [15:0] a_lines, b_lines;

  logic step_req, lock_req, running;
  logic [LEVEL_LEN-1:0] level;
  logic [15:0] lines_total;

  int n_chk = 0;
  int n_pass = 0;
  int n;

  drop_scheduler #(.PERIOD_SCALE(1_000_000), .SOFT_PERIOD(5), .LOCK_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start & ~sel), .game_over_i(game_over & ~sel),
    .soft_drop_i(soft_drop & ~sel), .hard_drop_i(hard_drop & ~sel),
    .piece_moved_i(piece_moved & ~sel),
    .step_req_o(a_step_req), .step_ack_i(step_ack & ~sel), .step_ok_i(step_ok),
    .lock_req_o(a_lock_req), .lock_ack_i(lock_ack & ~sel), .lines_cleared_i(lines_cleared),
    .level_o(a_level), .lines_total_o(a_lines), .running_o(a_running));

  drop_scheduler #(.PERIOD_SCALE(1_000_000), .SOFT_PERIOD(5), .LOCK_CYCLES(20),
                   .START_LEVEL(13)) dut13 (
    .clk(clk), .rst_n(rst_n),
    .start_i(start & sel), .game_over_i(game_over & sel),
    .soft_drop_i(soft_drop & sel), .hard_drop_i(hard_drop & sel),
    .piece_moved_i(piece_moved & sel),
    .step_req_o(b_step_req), .step_ack_i(step_ack & sel), .step_ok_i(step_ok),
    .lock_req_o(b_lock_req), .lock_ack_i(lock_ack & sel), .lines_cleared_i(lines_cleared),
    .level_o(b_level), .lines_total_o(b_lines), .running_o(b_running));

  assign step_req    = sel ? b_step_req : a_step_req;
  assign lock_req    = sel ? b_lock_req : a_lock_req;
  assign running     = sel ? b_running  : a_running;
  assign level       = sel ? b_level    : a_level;
  assign lines_total = sel ? b_lines    : a_lines;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance to the next falling edge and retire any one-cycle pulses.
  task automatic step();
    @(negedge clk);
    start = 0; game_over = 0; hard_drop = 0; piece_moved = 0;
    step_ack = 0; lock_ack = 0;
  endtask

  // Falling edges until the selected request is seen high (bounded).
  task automatic wait_for(input bit lock, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(lock ? lock_req : step_req) && cnt < 500);
  endtask

  task automatic ack_step(input logic ok);
    step_ack = 1; step_ok = ok;
    step();
  endtask

  task automatic ack_lock(input logic [2:0] lc);
    lock_ack = 1; lines_cleared = lc;
    step();
  endtask

  // Hard-drop into a blocked step, then commit with lc lines.
  task automatic do_lock(input logic [2:0] lc);
    int k;
    hard_drop = 1;
    wait_for(1'b0, k);
    chk("hd_req", 32'(k), 1);
    ack_step(1'b0);
    chk("hd_lock_req", 32'(lock_req), 1);
    ack_lock(lc);
    chk("lock_drop", 32'(lock_req), 0);
  endtask

  initial begin
    sel = 0; rst_n = 0;
    start = 0; game_over = 0; soft_drop = 0; hard_drop = 0; piece_moved = 0;
    step_ack = 0; step_ok = 0; lock_ack = 0; lines_cleared = 0;
    repeat (3) @(negedge clk);
    chk("rst_step_req", 32'(step_req), 0);
    chk("rst_lock_req", 32'(lock_req), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_lines", 32'(lines_total), 0);
    rst_n = 1;
    step();

    // 1: gravity at level 0 and basic step handshake
    start = 1;
    wait_for(1'b0, n);
    chk("first_step", 32'(n), 101);
    chk("running", 32'(running), 1);
    step(); step();
    chk("req_held", 32'(step_req), 1);
    ack_step(1'b1);
    chk("req_drop", 32'(step_req), 0);
    wait_for(1'b0, n);
    chk("grav_l0", 32'(n), 100);

    // 2: soft drop spacing, then release
    soft_drop = 1;
    ack_step(1'b1);
    wait_for(1'b0, n);
    chk("soft_1", 32'(n), 5);
    ack_step(1'b1);
    wait_for(1'b0, n);
    chk("soft_2", 32'(n), 5);
    soft_drop = 0;
    ack_step(1'b1);
    wait_for(1'b0, n);
    chk("soft_rel", 32'(n), 100);

    // 3: lock delay, line counting, level advance, clamp of lines_cleared
    ack_step(1'b0);
    wait_for(1'b1, n);
    chk("lock_delay", 32'(n), 20);
    ack_lock(3'd4);
    chk("lines_4", 32'(lines_total), 4);
    do_lock(3'd4);
    chk("lines_8", 32'(lines_total), 8);
    chk("level_0", 32'(level), 0);
    do_lock(3'd4);
    chk("lines_12", 32'(lines_total), 12);
    chk("level_1", 32'(level), 1);
    wait_for(1'b0, n);
    chk("grav_l1", 32'(n), 80);
    ack_step(1'b0);
    wait_for(1'b1, n);
    chk("lock_delay2", 32'(n), 20);
    ack_lock(3'd7);
    chk("lines_clamp", 32'(lines_total), 16);

    // 4: hard drop chain with one idle cycle between requests
    hard_drop = 1;
    wait_for(1'b0, n);
    chk("hd_first", 32'(n), 1);
    for (int i = 0; i < 3; i++) begin
      ack_step(1'b1);
      chk("hd_gap_low", 32'(step_req), 0);
      step();
      chk("hd_gap_high", 32'(step_req), 1);
    end
    ack_step(1'b0);
    chk("hd_commit", 32'(lock_req), 1);
    chk("hd_commit_sreq", 32'(step_req), 0);
    ack_lock(3'd0);
    chk("lines_0", 32'(lines_total), 16);

    // 5: piece_moved during lock, including on the expiry cycle
    wait_for(1'b0, n);
    chk("grav_after_hd", 32'(n), 80);
    ack_step(1'b0);
    repeat (9) step();
    piece_moved = 1;
    step();
    chk("pm_no_lock", 32'(lock_req), 0);
    wait_for(1'b0, n);
    chk("pm_retry", 32'(n), 80);
    ack_step(1'b0);
    repeat (19) step();
    piece_moved = 1;
    step();
    chk("pm_beats_exp", 32'(lock_req), 0);
    wait_for(1'b0, n);
    chk("pm_retry2", 32'(n), 80);

    // 6: start level 13, saturation, game_over and async reset
    sel = 1;
    start = 1;
    wait_for(1'b0, n);
    chk("l13_step", 32'(n), 2);
    chk("l13_level", 32'(level), 13);
    for (int i = 0; i < 3; i++) do_lock(3'd4);
    chk("l14_level", 32'(level), 14);
    chk("l14_lines", 32'(lines_total), 12);
    for (int i = 0; i < 3; i++) do_lock(3'd4);
    chk("sat_level", 32'(level), 14);
    chk("sat_lines", 32'(lines_total), 24);
    wait_for(1'b0, n);
    chk("l14_step", 32'(n), 1);
    game_over = 1; step_ack = 1; step_ok = 0;
    step();
    chk("go_sreq", 32'(step_req), 0);
    chk("go_lreq", 32'(lock_req), 0);
    chk("go_running", 32'(running), 0);
    chk("go_level", 32'(level), 14);
    chk("go_lines", 32'(lines_total), 24);
    start = 1;
    wait_for(1'b0, n);
    chk("restart_step", 32'(n), 2);
    chk("restart_lines", 32'(lines_total), 0);
    hard_drop = 1;
    step();
    ack_step(1'b0);
    chk("pre_rst_lreq", 32'(lock_req), 1);
    #2 rst_n = 0;
    #1;
    chk("async_lreq", 32'(lock_req), 0);
    chk("async_level", 32'(level), 0);
    chk("async_running", 32'(running), 0);
    @(negedge clk);
    rst_n = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
